// File: rtl/alu_pwr_seq_if.sv
// Requester-side handshake and status bundle for the ALU power/isolation sequencer.
interface alu_pwr_seq_if;
  logic       op_req;
  logic       alu_busy;
  logic       sleep_req;
  logic       op_grant;
  logic       alu_pwr_en;
  logic       iso_en;
  logic       alu_rst_n;
  logic [2:0] pwr_state;
  logic [7:0] pwr_up_cnt;

  modport master (
    output op_req, alu_busy, sleep_req,
    input  op_grant, alu_pwr_en, iso_en, alu_rst_n, pwr_state, pwr_up_cnt
  );

  modport slave (
    input  op_req, alu_busy, sleep_req,
    output op_grant, alu_pwr_en, iso_en, alu_rst_n, pwr_state, pwr_up_cnt
  );
endinterface

// File: rtl/alu_pwr_seq.sv
// Power/isolation sequencer for the power-gated ALU: orders rail, reset and clamp,
// grants issue only in ON and auto-gates after an idle timeout.
module alu_pwr_seq #(
  parameter int unsigned IDLE_TIMEOUT = 16,
  parameter int unsigned PWR_DLY      = 4,
  parameter int unsigned RST_DLY      = 2,
  parameter int unsigned ISO_DLY      = 2
) (
  input  logic          clk,
  input  logic          rst,
  alu_pwr_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    PWR_UP  = 3'd1,
    RST_REL = 3'd2,
    ON      = 3'd3,
    ISO     = 3'd4
  } state_t;

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_TIMEOUT - 1);
  localparam logic [7:0] PWR_LD    = 8'(PWR_DLY - 1);
  localparam logic [7:0] RST_LD    = 8'(RST_DLY - 1);
  localparam logic [7:0] ISO_LD    = 8'(ISO_DLY - 1);

  state_t     state;
  state_t     nxt;
  logic [7:0] dly_cnt;
  logic [7:0] idle_cnt;
  logic       idle;

  assign idle         = !bus.op_req && !bus.alu_busy && !bus.sleep_req;
  assign bus.op_grant = (state == ON) && !bus.sleep_req;

  always_comb begin
    nxt = state;
    case (state)
      OFF:     if (bus.op_req && !bus.sleep_req) nxt = PWR_UP;
      PWR_UP:  if (dly_cnt == '0) nxt = RST_REL;
      RST_REL: if (dly_cnt == '0) nxt = ON;
      ON: begin
        if (bus.sleep_req && !bus.alu_busy)    nxt = ISO;
        else if (idle && idle_cnt == IDLE_LAST) nxt = ISO;
      end
      ISO:     if (dly_cnt == '0) nxt = OFF;
      default: nxt = OFF;
    endcase
  end

  // Moore outputs are registered from the next state so they change on the same
  // edge as the state register and never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= OFF;
      dly_cnt        <= '0;
      idle_cnt       <= '0;
      bus.pwr_up_cnt <= '0;
      bus.pwr_state  <= '0;
      bus.alu_pwr_en <= 1'b0;
      bus.iso_en     <= 1'b1;
      bus.alu_rst_n  <= 1'b0;
    end else begin
      state         <= nxt;
      bus.pwr_state <= nxt;

      case (nxt)
        PWR_UP:  {bus.alu_pwr_en, bus.iso_en, bus.alu_rst_n} <= 3'b110;
        RST_REL: {bus.alu_pwr_en, bus.iso_en, bus.alu_rst_n} <= 3'b111;
        ON:      {bus.alu_pwr_en, bus.iso_en, bus.alu_rst_n} <= 3'b101;
        ISO:     {bus.alu_pwr_en, bus.iso_en, bus.alu_rst_n} <= 3'b111;
        default: {bus.alu_pwr_en, bus.iso_en, bus.alu_rst_n} <= 3'b010;
      endcase

      if (nxt != state) begin
        case (nxt)
          PWR_UP:  dly_cnt <= PWR_LD;
          RST_REL: dly_cnt <= RST_LD;
          ISO:     dly_cnt <= ISO_LD;
          default: dly_cnt <= '0;
        endcase
      end else if (dly_cnt != '0) begin
        dly_cnt <= dly_cnt - 8'd1;
      end

      if (state != ON || nxt != ON || !idle) idle_cnt <= '0;
      else                                   idle_cnt <= idle_cnt + 8'd1;

      if (state == RST_REL && nxt == ON && bus.pwr_up_cnt != 8'hFF)
        bus.pwr_up_cnt <= bus.pwr_up_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_pwr_seq.sv
// Directed bench for alu_pwr_seq: per-cycle vector table plus a wake/saturation loop.
module tb_alu_pwr_seq;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic chk_en = 1'b0;

  alu_pwr_seq_if bus_if ();

  alu_pwr_seq #(
    .IDLE_TIMEOUT(16),
    .PWR_DLY     (4),
    .RST_DLY     (2),
    .ISO_DLY     (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       op;
    logic       busy;
    logic       sleep;
    int         reps;
    logic [2:0] st;
    logic       grant;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [2:0] outs_of(input logic [2:0] st);
    case (st)
      3'd1:    return 3'b110;
      3'd2:    return 3'b111;
      3'd3:    return 3'b101;
      3'd4:    return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  task automatic add(input logic r, input logic op, input logic busy, input logic sleep,
                     input int reps, input logic [2:0] st, input logic grant,
                     input logic [7:0] cnt);
    vec_t v;
    v.rst = r; v.op = op; v.busy = busy; v.sleep = sleep;
    v.reps = reps; v.st = st; v.grant = grant; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name, input logic [2:0] st, input logic grant,
                             input logic [7:0] cnt);
    logic [2:0] o;
    o = {bus_if.alu_pwr_en, bus_if.iso_en, bus_if.alu_rst_n};
    total += 3;
    if (bus_if.pwr_state !== st || bus_if.op_grant !== grant) begin
      bad++;
      $display("FAIL %s state/grant: got %0d/%0b want %0d/%0b at %0t",
               name, bus_if.pwr_state, bus_if.op_grant, st, grant, $time);
    end
    if (o !== outs_of(st)) begin
      bad++;
      $display("FAIL %s pwr/iso/rstn: got %b want %b at %0t", name, o, outs_of(st), $time);
    end
    if (bus_if.pwr_up_cnt !== cnt) begin
      bad++;
      $display("FAIL %s pwr_up_cnt: got %0d want %0d at %0t",
               name, bus_if.pwr_up_cnt, cnt, $time);
    end
  endtask

  // Clamp must be on whenever the ALU is unpowered or held in reset.
  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (!bus_if.iso_en && !(bus_if.alu_pwr_en && bus_if.alu_rst_n)) begin
        bad++;
        $display("FAIL iso_invariant: iso=%b pwr=%b rstn=%b at %0t",
                 bus_if.iso_en, bus_if.alu_pwr_en, bus_if.alu_rst_n, $time);
      end
    end
  end

  initial begin
    int exp_cnt;
    int k;
    rst = 1'b1;
    bus_if.op_req = 1'b0; bus_if.alu_busy = 1'b0; bus_if.sleep_req = 1'b0;

    //   rst op busy slp reps st grant cnt
    add(1, 0, 0, 0, 2,  0, 0, 0);   // reset
    add(0, 1, 0, 0, 4,  1, 0, 0);   // wake: PWR_UP x4
    add(0, 1, 0, 0, 2,  2, 0, 0);   // RST_REL x2
    add(0, 1, 0, 0, 1,  3, 1, 1);   // ON 7 edges after op_req
    add(0, 0, 0, 0, 15, 3, 1, 1);   // idle timeout
    add(0, 0, 0, 0, 2,  4, 0, 1);
    add(0, 0, 0, 0, 1,  0, 0, 1);
    add(0, 1, 0, 0, 4,  1, 0, 1);   // rewake
    add(0, 1, 0, 0, 2,  2, 0, 1);
    add(0, 1, 0, 0, 1,  3, 1, 2);
    add(0, 0, 0, 0, 15, 3, 1, 2);   // 15 idle, then op_req pulse on timeout cycle
    add(0, 1, 0, 0, 1,  3, 1, 2);
    add(0, 0, 0, 0, 15, 3, 1, 2);
    add(0, 0, 0, 0, 2,  4, 0, 2);
    add(0, 0, 0, 0, 1,  0, 0, 2);
    add(0, 1, 0, 0, 4,  1, 0, 2);   // rewake
    add(0, 1, 0, 0, 2,  2, 0, 2);
    add(0, 1, 0, 0, 1,  3, 1, 3);
    add(0, 0, 1, 1, 5,  3, 0, 3);   // sleep while busy holds ON, no grant
    add(0, 0, 0, 1, 2,  4, 0, 3);
    add(0, 0, 0, 1, 1,  0, 0, 3);
    add(0, 1, 0, 1, 3,  0, 0, 3);   // sleep beats op_req in OFF
    add(0, 1, 0, 0, 4,  1, 0, 3);
    add(0, 1, 0, 0, 1,  2, 0, 3);
    add(1, 1, 0, 0, 1,  0, 0, 0);   // reset in RST_REL
    add(0, 0, 0, 0, 2,  0, 0, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      bus_if.op_req = tbl[i].op;
      bus_if.alu_busy = tbl[i].busy;
      bus_if.sleep_req = tbl[i].sleep;
      for (int r = 0; r < tbl[i].reps; r++) begin
        step();
        chk_en = 1'b1;
        check_state($sformatf("vec%0d.%0d", i, r), tbl[i].st, tbl[i].grant, tbl[i].cnt);
      end
    end

    // Repeated wake cycles: counter must saturate at 255.
    for (int i = 1; i <= 260; i++) begin
      bus_if.op_req = 1'b1;
      bus_if.sleep_req = 1'b0;
      k = 0;
      while (bus_if.pwr_state !== 3'd3 && k < 30) begin
        step();
        k++;
      end
      exp_cnt = (i > 255) ? 255 : i;
      total++;
      if (bus_if.pwr_state !== 3'd3) begin
        bad++;
        $display("FAIL wake%0d timeout: state=%0d want 3", i, bus_if.pwr_state);
      end else if (bus_if.pwr_up_cnt !== 8'(exp_cnt)) begin
        bad++;
        $display("FAIL wake%0d pwr_up_cnt: got %0d want %0d", i, bus_if.pwr_up_cnt, exp_cnt);
      end
      bus_if.sleep_req = 1'b1;
      step();
      total++;
      if (bus_if.pwr_state !== 3'd4) begin
        bad++;
        $display("FAIL sleep%0d: state=%0d want 4", i, bus_if.pwr_state);
      end
    end
    bus_if.sleep_req = 1'b0;
    bus_if.op_req = 1'b0;
    step(); step();
    check_state("sat_final", 3'd0, 1'b0, 8'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
